csr_trap_cause: RTL and testbench
=================================

Name: csr_trap_cause

Overview:
Parametrised machine trap-cause unit: mcause plus mtval, with a trap-state FSM.
- Prioritises N exception sources and M interrupt lines into a RISC-V cause code.
- Captures the trap value and tracks trap nesting, flagging a double fault.
- Sits in the CSR file beside the other machine CSRs on the shared en/addr/set/clear bus; the trap controller drives it.

Parameters:
NUM_EXC, 6, number of exception sources; index 0 has highest priority.
NUM_IRQ, 3, number of interrupt lines; index 0 has highest priority.
CODE_W, 5, width of the stored cause-code field (mcause[CODE_W-1:0]); range 4..31.
EXC_CODE_LUT, {5'd5,5'd11,5'd3,5'd2,5'd1,5'd0}, packed NUM_EXC*CODE_W; entry i = bits [i*CODE_W +: CODE_W].
IRQ_CODE_LUT, {5'd7,5'd3,5'd11}, packed NUM_IRQ*CODE_W; default gives MEI > MSI > MTI.
MCAUSE_ADDR, 12'h342, mcause CSR address.
MTVAL_ADDR, 12'h343, mtval CSR address.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
en_i  in  1  CSR access strobe
addr_i  in  12  CSR address
set_i  in  32  CSR bits to set
clear_i  in  32  CSR bits to clear
ack_o  out  1  en_i && addr_i matches an implemented address (combinational)
rdata_o  out  32  read value of the addressed CSR when ack_o, else 0 (combinational)
exc_valid_i  in  NUM_EXC  exception requests this cycle; more than one may be set
exc_tval_i  in  32  trap value for the winning exception
irq_pending_i  in  NUM_IRQ  pending and enabled interrupts
irq_take_i  in  1  trap controller commits to taking an interrupt this cycle
mret_i  in  1  trap return
trap_o  out  1  one-cycle pulse, the cycle after a trap is captured
in_trap_o  out  1  high while FSM is in TRAP or FAULT
double_fault_o  out  1  sticky; set on entry to FAULT
mcause_o  out  32  {int, zeros, code}
mtval_o  out  32  current mtval

Behaviour:
- Reset: mcause=0, mtval=0, FSM=RUN, trap_o=0, double_fault_o=0.
- CSR write, on ack only: next = (cur & ~clear_i) | set_i, applied per register.
  - mcause: only bit31 and [CODE_W-1:0] are writable; all other bits read 0.
  - mtval: all 32 bits writable.
- Exception event (exc = |exc_valid_i), in RUN:
  - The lowest set index i wins.
  - Next cycle: mcause = {1'b0, 0, EXC_CODE_LUT[i]}, mtval = exc_tval_i, FSM goes to TRAP, trap_o=1.
- Interrupt event: irq_take_i && |irq_pending_i && !exc, in RUN.
  - The lowest set index j wins.
  - Next cycle: mcause = {1'b1, 0, IRQ_CODE_LUT[j]}, mtval = 0, FSM goes to TRAP, trap_o=1.
  - irq_take_i with no pending line: ignored.
- Exception beats interrupt in the same cycle.
- Hardware capture beats a CSR write to the same register in the same cycle; the CSR write is dropped, ack_o still asserts.
- FSM transitions:
  - RUN -> TRAP on any event.
  - TRAP -> RUN on mret_i.
  - TRAP -> FAULT on an exception without mret_i in the same cycle. mcause and mtval are preserved, double_fault_o=1, no trap_o pulse.
  - TRAP plus interrupt: ignored, no capture.
  - TRAP with mret_i and exc in the same cycle: go to RUN (return wins); the exception is not captured.
  - FAULT: absorbing state; only reset exits; mret_i ignored; CSR writes still allowed.
- mret_i in RUN: no effect.
- Reset mid-trap: all state clears immediately (asynchronous).
- Reads return the pre-update register value (the value before the clock edge).

Optional Feature:
CSR_TRAP_COUNT_EN.
- Defined: adds a 16-bit trap counter at address 12'h7C0.
  - Increments on every trap_o pulse and saturates at 16'hFFFF.
  - Writable via set/clear; hardware increment beats a CSR write in the same cycle.
  - ack_o covers the address; rdata_o = {16'b0, cnt}.
- Undefined: 12'h7C0 is not acked and no counter logic exists.

Test Plan:
- Reset, then read 0x342 and 0x343 -> both 0, ack_o=1; read 0x344 -> ack_o=0, rdata_o=0.
- exc_valid_i=6'b000100, tval=32'hDEADBEEF -> next cycle mcause=2, mtval=DEADBEEF, trap_o pulses 1 cycle, in_trap_o=1.
- exc_valid_i=6'b010100 with irq_take_i=1, irq_pending_i=3'b111 in the same cycle -> mcause=2 (index 2 beats index 4; exception beats interrupt).
- In RUN, irq_pending_i=3'b110, irq_take_i=1 -> mcause=32'h80000003, mtval=0. Then mret_i -> RUN. Then exc_valid_i[4] -> mcause=11.
- In TRAP, exc_valid_i[0] -> double_fault_o=1, mcause unchanged, mret_i ignored. Assert rst_i mid-cycle -> all outputs 0 immediately.
- In RUN: set_i=32'h8000001F, clear_i=0 at 0x342 -> mcause=8000001F. Then clear_i=32'h80000000 -> 0000001F. A capture in the same cycle as a write -> the captured value wins.

Source files
------------

// File: rtl/csr_trap_cause.sv
// Machine trap-cause unit: mcause/mtval CSRs, exception/interrupt prioritisation and trap FSM.
// Optional trap counter at 12'h7C0 is built only when CSR_TRAP_COUNT_EN is defined.
module csr_trap_cause #(
  parameter int NUM_EXC = 6,
  parameter int NUM_IRQ = 3,
  parameter int CODE_W  = 5,
  parameter logic [NUM_EXC*CODE_W-1:0] EXC_CODE_LUT = {5'd5, 5'd11, 5'd3, 5'd2, 5'd1, 5'd0},
  parameter logic [NUM_IRQ*CODE_W-1:0] IRQ_CODE_LUT = {5'd7, 5'd3, 5'd11},
  parameter logic [11:0] MCAUSE_ADDR = 12'h342,
  parameter logic [11:0] MTVAL_ADDR  = 12'h343
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [11:0]        addr_i,
  input  logic [31:0]        set_i,
  input  logic [31:0]        clear_i,
  output logic               ack_o,
  output logic [31:0]        rdata_o,
  input  logic [NUM_EXC-1:0] exc_valid_i,
  input  logic [31:0]        exc_tval_i,
  input  logic [NUM_IRQ-1:0] irq_pending_i,
  input  logic               irq_take_i,
  input  logic               mret_i,
  output logic               trap_o,
  output logic               in_trap_o,
  output logic               double_fault_o,
  output logic [31:0]        mcause_o,
  output logic [31:0]        mtval_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_TRAP  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              int_q, int_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [31:0]       mtval_q, mtval_d;
  logic              trap_q, trap_d;
  logic              dfault_q, dfault_d;

  logic              sel_mcause, sel_mtval;
  logic              exc_any, irq_any, cap_exc, cap_irq;
  logic [CODE_W-1:0] exc_code, irq_code;
  logic              int_wr;
  logic [CODE_W-1:0] code_wr;
  logic [31:0]       mtval_wr;

  // Scan high to low so the lowest set index is the last assignment and wins.
  always_comb begin
    exc_code = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (exc_valid_i[i]) exc_code = EXC_CODE_LUT[i*CODE_W +: CODE_W];
    end
  end

  always_comb begin
    irq_code = '0;
    for (int j = NUM_IRQ - 1; j >= 0; j--) begin
      if (irq_pending_i[j]) irq_code = IRQ_CODE_LUT[j*CODE_W +: CODE_W];
    end
  end

  assign exc_any = |exc_valid_i;
  assign irq_any = irq_take_i && (|irq_pending_i) && !exc_any;
  assign cap_exc = (state_q == ST_RUN) && exc_any;
  assign cap_irq = (state_q == ST_RUN) && irq_any;

  assign sel_mcause = en_i && (addr_i == MCAUSE_ADDR);
  assign sel_mtval  = en_i && (addr_i == MTVAL_ADDR);

  assign int_wr   = (int_q & ~clear_i[31]) | set_i[31];
  assign code_wr  = (code_q & ~clear_i[CODE_W-1:0]) | set_i[CODE_W-1:0];
  assign mtval_wr = (mtval_q & ~clear_i) | set_i;

  always_comb begin
    mcause_o              = '0;
    mcause_o[31]          = int_q;
    mcause_o[CODE_W-1:0]  = code_q;
  end

  assign mtval_o        = mtval_q;
  assign trap_o         = trap_q;
  assign in_trap_o      = (state_q == ST_TRAP) || (state_q == ST_FAULT);
  assign double_fault_o = dfault_q;

  // Hardware capture takes precedence over a same-cycle CSR write.
  always_comb begin
    int_d   = int_q;
    code_d  = code_q;
    mtval_d = mtval_q;
    if (cap_exc) begin
      int_d   = 1'b0;
      code_d  = exc_code;
      mtval_d = exc_tval_i;
    end else if (cap_irq) begin
      int_d   = 1'b1;
      code_d  = irq_code;
      mtval_d = '0;
    end else begin
      if (sel_mcause) begin
        int_d  = int_wr;
        code_d = code_wr;
      end
      if (sel_mtval) mtval_d = mtval_wr;
    end
  end

  always_comb begin
    state_d  = state_q;
    dfault_d = dfault_q;
    trap_d   = cap_exc || cap_irq;
    case (state_q)
      ST_RUN: begin
        if (cap_exc || cap_irq) state_d = ST_TRAP;
      end
      ST_TRAP: begin
        if (mret_i) begin
          state_d = ST_RUN;
        end else if (exc_any) begin
          state_d  = ST_FAULT;
          dfault_d = 1'b1;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      int_q    <= 1'b0;
      code_q   <= '0;
      mtval_q  <= '0;
      trap_q   <= 1'b0;
      dfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      int_q    <= int_d;
      code_q   <= code_d;
      mtval_q  <= mtval_d;
      trap_q   <= trap_d;
      dfault_q <= dfault_d;
    end
  end

`ifdef CSR_TRAP_COUNT_EN
  localparam logic [11:0] CNT_ADDR = 12'h7C0;
  logic        sel_cnt;
  logic [15:0] cnt_q, cnt_d;

  assign sel_cnt = en_i && (addr_i == CNT_ADDR);

  // Increment on the trap_o pulse, saturating; it also overrides a same-cycle write.
  always_comb begin
    cnt_d = cnt_q;
    if (trap_q) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (sel_cnt) begin
      cnt_d = (cnt_q & ~clear_i[15:0]) | set_i[15:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign ack_o = sel_mcause || sel_mtval || sel_cnt;

  always_comb begin
    rdata_o = '0;
    if (sel_mcause)     rdata_o = mcause_o;
    else if (sel_mtval) rdata_o = mtval_q;
    else if (sel_cnt)   rdata_o = {16'b0, cnt_q};
  end
`else
  assign ack_o = sel_mcause || sel_mtval;

  always_comb begin
    rdata_o = '0;
    if (sel_mcause)     rdata_o = mcause_o;
    else if (sel_mtval) rdata_o = mtval_q;
  end
`endif

endmodule

// File: tb/tb_csr_trap_cause.sv
// Directed bench for csr_trap_cause: reset, CSR access, capture priority, FSM paths, async reset.
module tb_csr_trap_cause;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] addr;
  logic [31:0] set_v, clear_v;
  logic        ack;
  logic [31:0] rdata;
  logic [5:0]  exc_valid;
  logic [31:0] exc_tval;
  logic [2:0]  irq_pending;
  logic        irq_take, mret;
  logic        trap, in_trap, dfault;
  logic [31:0] mcause, mtval;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_trap_cause dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .addr_i(addr), .set_i(set_v), .clear_i(clear_v),
    .ack_o(ack), .rdata_o(rdata), .exc_valid_i(exc_valid), .exc_tval_i(exc_tval),
    .irq_pending_i(irq_pending), .irq_take_i(irq_take), .mret_i(mret),
    .trap_o(trap), .in_trap_o(in_trap), .double_fault_o(dfault),
    .mcause_o(mcause), .mtval_o(mtval)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en = 1'b0; addr = '0; set_v = '0; clear_v = '0;
    exc_valid = '0; exc_tval = '0; irq_pending = '0; irq_take = 1'b0; mret = 1'b0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12;
    chk("rst_mcause", mcause, 32'h0);
    chk("rst_mtval", mtval, 32'h0);
    chk("rst_trap", {31'b0, trap}, 32'h0);
    chk("rst_in_trap", {31'b0, in_trap}, 32'h0);
    chk("rst_dfault", {31'b0, dfault}, 32'h0);
    rst = 1'b0;

    // Reads after reset
    en = 1'b1; addr = 12'h342; #1;
    chk("rd342_ack", {31'b0, ack}, 32'h1);
    chk("rd342_data", rdata, 32'h0);
    addr = 12'h343; #1;
    chk("rd343_ack", {31'b0, ack}, 32'h1);
    chk("rd343_data", rdata, 32'h0);
    addr = 12'h344; #1;
    chk("rd344_ack", {31'b0, ack}, 32'h0);
    chk("rd344_data", rdata, 32'h0);
    addr = 12'h7C0; #1;
`ifdef CSR_TRAP_COUNT_EN
    chk("rd7c0_ack", {31'b0, ack}, 32'h1);
`else
    chk("rd7c0_ack", {31'b0, ack}, 32'h0);
`endif
    idle();

    // Single exception, index 2 -> code 2
    exc_valid = 6'b000100; exc_tval = 32'hDEADBEEF;
    tick();
    idle();
    chk("exc2_mcause", mcause, 32'h2);
    chk("exc2_mtval", mtval, 32'hDEADBEEF);
    chk("exc2_trap", {31'b0, trap}, 32'h1);
    chk("exc2_in_trap", {31'b0, in_trap}, 32'h1);
    tick();
    chk("exc2_trap_pulse_end", {31'b0, trap}, 32'h0);
    chk("exc2_in_trap_hold", {31'b0, in_trap}, 32'h1);
    mret = 1'b1;
    tick();
    idle();
    chk("mret_run", {31'b0, in_trap}, 32'h0);

    // Exception index 2 beats index 4 and a concurrent interrupt
    exc_valid = 6'b010100; exc_tval = 32'h00001234; irq_take = 1'b1; irq_pending = 3'b111;
    tick();
    idle();
    chk("prio_mcause", mcause, 32'h2);
    chk("prio_mtval", mtval, 32'h00001234);
    mret = 1'b1;
    tick();
    idle();

    // irq_take with no pending line is ignored
    irq_take = 1'b1;
    tick();
    idle();
    chk("irq_none_trap", {31'b0, trap}, 32'h0);
    chk("irq_none_in_trap", {31'b0, in_trap}, 32'h0);
    chk("irq_none_mcause", mcause, 32'h2);

    // Interrupt: pending 110 -> index 1 -> MSI code 3
    irq_take = 1'b1; irq_pending = 3'b110;
    tick();
    idle();
    chk("irq_mcause", mcause, 32'h80000003);
    chk("irq_mtval", mtval, 32'h0);
    chk("irq_trap", {31'b0, trap}, 32'h1);

    // mret and exception together in TRAP: return wins, no capture
    mret = 1'b1; exc_valid = 6'b000010; exc_tval = 32'h11111111;
    tick();
    idle();
    chk("mret_exc_run", {31'b0, in_trap}, 32'h0);
    chk("mret_exc_mcause", mcause, 32'h80000003);
    chk("mret_exc_dfault", {31'b0, dfault}, 32'h0);

    // Exception index 4 -> code 11
    exc_valid = 6'b010000; exc_tval = 32'h000000A5;
    tick();
    idle();
    chk("exc4_mcause", mcause, 32'hB);

    // Interrupt while in TRAP is ignored
    irq_take = 1'b1; irq_pending = 3'b001;
    tick();
    idle();
    chk("trap_irq_mcause", mcause, 32'hB);
    chk("trap_irq_trap", {31'b0, trap}, 32'h0);

    // Exception in TRAP -> FAULT, cause/value preserved
    exc_valid = 6'b000001; exc_tval = 32'h00000077;
    tick();
    idle();
    chk("fault_dfault", {31'b0, dfault}, 32'h1);
    chk("fault_mcause", mcause, 32'hB);
    chk("fault_mtval", mtval, 32'hA5);
    chk("fault_trap", {31'b0, trap}, 32'h0);
    mret = 1'b1;
    tick();
    idle();
    chk("fault_mret_ignored", {31'b0, in_trap}, 32'h1);
    chk("fault_sticky", {31'b0, dfault}, 32'h1);

    // CSR write still allowed in FAULT
    en = 1'b1; addr = 12'h343; clear_v = 32'hFFFFFFFF;
    tick();
    idle();
    chk("fault_wr_mtval", mtval, 32'h0);

    // Asynchronous reset in the middle of a cycle
    #3;
    rst = 1'b1;
    #1;
    chk("arst_mcause", mcause, 32'h0);
    chk("arst_in_trap", {31'b0, in_trap}, 32'h0);
    chk("arst_dfault", {31'b0, dfault}, 32'h0);
    chk("arst_trap", {31'b0, trap}, 32'h0);
    #2;
    rst = 1'b0;
    tick();

    // mcause writes: only bit31 and code bits stick; reads show pre-update value
    en = 1'b1; addr = 12'h342; set_v = 32'h8000001F; #1;
    chk("wr_pre_rdata", rdata, 32'h0);
    tick();
    idle();
    chk("wr_set_mcause", mcause, 32'h8000001F);
    en = 1'b1; addr = 12'h342; clear_v = 32'h80000000;
    tick();
    idle();
    chk("wr_clr_mcause", mcause, 32'h0000001F);
    en = 1'b1; addr = 12'h342; set_v = 32'hFFFFFFFF;
    tick();
    idle();
    chk("wr_mask_mcause", mcause, 32'h8000001F);

    // Capture beats a same-cycle mcause write, ack still given
    en = 1'b1; addr = 12'h342; clear_v = 32'hFFFFFFFF; set_v = 32'h10;
    exc_valid = 6'b001000; exc_tval = 32'h55; #1;
    chk("cap_wr_ack", {31'b0, ack}, 32'h1);
    tick();
    idle();
    chk("cap_wr_mcause", mcause, 32'h3);
    chk("cap_wr_mtval", mtval, 32'h55);
    mret = 1'b1;
    tick();
    idle();

    // Interrupt capture beats a same-cycle mtval write; pending 100 -> code 7
    en = 1'b1; addr = 12'h343; set_v = 32'h0000FFFF; irq_take = 1'b1; irq_pending = 3'b100;
    tick();
    idle();
    chk("cap_irq_mcause", mcause, 32'h80000007);
    chk("cap_irq_mtval", mtval, 32'h0);

    // mtval set/clear inside TRAP
    en = 1'b1; addr = 12'h343; set_v = 32'h0000F0F0;
    tick();
    idle();
    chk("mtval_set", mtval, 32'h0000F0F0);
    en = 1'b1; addr = 12'h343; set_v = 32'h1; clear_v = 32'h000000F0;
    tick();
    chk("mtval_setclr", mtval, 32'h0000F001);
    chk("mtval_read", rdata, 32'h0000F001);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
